// File: rtl/alu_word_seq_pkg.sv
// Shared definitions for the 16-bit word sequencer: ALU opcode mnemonics,
// sequencer state encoding and a byte-select helper.
package alu_word_seq_pkg;

    typedef enum logic [2:0] {
        kAND = 3'd0,
        kLSH = 3'd1,
        kRSH = 3'd2,
        kXOR = 3'd3
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        sel_byte = hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/alu_word_seq.sv
// Two-pass 16-bit sequencer driving an external combinational 8-bit ALU;
// chains shift/carry between byte passes and assembles result and flags.
module alu_word_seq
    import alu_word_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  CMD,
    input  logic [15:0] A16,
    input  logic [15:0] B16,
    input  logic        CIN,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        COUT,
    output logic        ZERO16,
    output logic        ODD16,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [2:0]  ALU_OP,
    output logic        ALU_SC_IN,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_SC_OUT,
    input  logic        ALU_BEVEN
);

    seq_state_t  state_q;
    op_mne       cmd_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        par1_q;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        busy_q;
    logic        done_q;
    logic        cout_q;
    logic        zero_q;
    logic        odd_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [2:0]  alu_op_q;
    logic        alu_sc_q;
    logic        hi_first_s;

    // Right shifts process the MSW first so its shift-out feeds the LSW.
    assign hi_first_s = (cmd_q == kRSH);

    // Merge the current ALU byte into the word being assembled.
    always_comb begin
        result_d = result_q;
        case (state_q)
            P1: begin
                if (hi_first_s) result_d[15:8] = ALU_OUT;
                else            result_d[7:0]  = ALU_OUT;
            end
            P2: begin
                if (hi_first_s) result_d[7:0]  = ALU_OUT;
                else            result_d[15:8] = ALU_OUT;
            end
            default: result_d = result_q;
        endcase
    end

    // Sequencer state, latched operands, ALU drive and result/flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            cmd_q    <= kAND;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            par1_q   <= 1'b0;
            result_q <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            odd_q    <= 1'b0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 3'd0;
            alu_sc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        state_q  <= P1;
                        cmd_q    <= op_mne'(CMD);
                        a_q      <= A16;
                        b_q      <= B16;
                        busy_q   <= 1'b1;
                        alu_a_q  <= sel_byte(A16, CMD == kRSH);
                        alu_b_q  <= sel_byte(B16, CMD == kRSH);
                        alu_op_q <= CMD;
                        alu_sc_q <= CIN;
                    end
                end
                P1: begin
                    state_q  <= P2;
                    result_q <= result_d;
                    par1_q   <= ALU_BEVEN;
                    alu_a_q  <= sel_byte(a_q, !hi_first_s);
                    alu_b_q  <= sel_byte(b_q, !hi_first_s);
                    alu_sc_q <= ALU_SC_OUT;
                end
                P2: begin
                    state_q  <= FIN;
                    result_q <= result_d;
                    cout_q   <= ALU_SC_OUT;
                    odd_q    <= par1_q ^ ALU_BEVEN;
                    zero_q   <= ~|result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    alu_a_q  <= 8'h00;
                    alu_b_q  <= 8'h00;
                    alu_op_q <= 3'd0;
                    alu_sc_q <= 1'b0;
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign COUT      = cout_q;
    assign ZERO16    = zero_q;
    assign ODD16     = odd_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_OP    = alu_op_q;
    assign ALU_SC_IN = alu_sc_q;

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed bench for alu_word_seq with a behavioural 8-bit ALU attached.
module tb_alu_word_seq;
    import alu_word_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, START, CIN;
    logic [2:0]  CMD;
    logic [15:0] A16, B16;
    logic        BUSY, DONE, COUT, ZERO16, ODD16;
    logic [15:0] RESULT;
    logic [7:0]  ALU_A, ALU_B, ALU_OUT;
    logic [2:0]  ALU_OP;
    logic        ALU_SC_IN, ALU_SC_OUT, ALU_BEVEN;

    int checks = 0;
    int failures = 0;
    int lat;
    int done_seen;
    int done_n[$];
    logic [15:0] done_res[$];

    always #5 CLK = ~CLK;

    alu_word_seq dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CMD(CMD), .A16(A16), .B16(B16),
        .CIN(CIN), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT),
        .ZERO16(ZERO16), .ODD16(ODD16), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN), .ALU_OUT(ALU_OUT),
        .ALU_SC_OUT(ALU_SC_OUT), .ALU_BEVEN(ALU_BEVEN)
    );

    // Reference single-byte ALU.
    always_comb begin
        ALU_OUT    = 8'h00;
        ALU_SC_OUT = 1'b0;
        case (ALU_OP)
            kAND:    ALU_OUT = ALU_A & ALU_B;
            kXOR:    ALU_OUT = ALU_A ^ ALU_B;
            kLSH:    begin ALU_OUT = {ALU_A[6:0], ALU_SC_IN}; ALU_SC_OUT = ALU_A[7]; end
            kRSH:    begin ALU_OUT = {ALU_SC_IN, ALU_A[7:1]}; ALU_SC_OUT = ALU_A[0]; end
            default: ALU_OUT = 8'h00;
        endcase
        ALU_BEVEN = ^ALU_OUT;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble inputs after accept, return cycles until DONE (99 on timeout).
    task automatic run_op(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output int latency);
        @(negedge CLK);
        CMD = cmd; A16 = a; B16 = b; CIN = cin; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0; A16 = 16'h5A5A; B16 = 16'hC3C3; CMD = kXOR; CIN = ~cin;
        latency = 99;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (DONE) begin
                latency = n;
                break;
            end
        end
    endtask

    task automatic check_flags(input string tag, input logic [15:0] res, input logic c,
                               input logic z, input logic o);
        check_val({tag, "_result"}, RESULT, res);
        check_val({tag, "_cout"}, {15'd0, COUT}, {15'd0, c});
        check_val({tag, "_zero"}, {15'd0, ZERO16}, {15'd0, z});
        check_val({tag, "_odd"}, {15'd0, ODD16}, {15'd0, o});
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; CMD = 3'd0; A16 = 16'h0000; B16 = 16'h0000; CIN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_busy", {15'd0, BUSY}, 16'h0000);
        check_val("rst_done", {15'd0, DONE}, 16'h0000);
        check_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_val("rst_alu_ab", {ALU_A, ALU_B}, 16'h0000);
        check_val("rst_alu_op_sc", {12'd0, ALU_OP, ALU_SC_IN}, 16'h0000);
        RESET = 1'b0;

        run_op(kLSH, 16'h80FF, 16'h0000, 1'b1, lat);
        check_val("lsh_latency", 16'(lat), 16'd3);
        check_val("lsh_busy_fin", {15'd0, BUSY}, 16'h0000);
        check_flags("lsh", 16'h01FF, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        check_val("lsh_done_pulse", {15'd0, DONE}, 16'h0000);
        check_val("lsh_hold", RESULT, 16'h01FF);

        run_op(kRSH, 16'h0180, 16'h0000, 1'b0, lat);
        check_val("rsh_latency", 16'(lat), 16'd3);
        check_flags("rsh", 16'h00C0, 1'b0, 1'b0, 1'b0);

        run_op(kXOR, 16'hA5A5, 16'hA5A5, 1'b1, lat);
        check_flags("xor", 16'h0000, 1'b0, 1'b1, 1'b0);

        run_op(kAND, 16'hF00F, 16'h3C3C, 1'b1, lat);
        check_flags("and", 16'h300C, 1'b0, 1'b0, 1'b0);

        run_op(3'b111, 16'hFFFF, 16'hFFFF, 1'b1, lat);
        check_val("undef_latency", 16'(lat), 16'd3);
        check_flags("undef", 16'h0000, 1'b0, 1'b1, 1'b0);

        // Second START during P1 must be ignored.
        @(negedge CLK);
        CMD = kLSH; A16 = 16'h0001; B16 = 16'h0000; CIN = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        CMD = kXOR; A16 = 16'hFFFF; B16 = 16'h0000; CIN = 1'b1;
        @(negedge CLK);
        check_val("p1_busy", {15'd0, BUSY}, 16'h0001);
        check_val("p1_alu_a", {8'd0, ALU_A}, 16'h0001);
        check_val("p1_alu_op", {13'd0, ALU_OP}, {13'd0, kLSH});
        @(negedge CLK);
        START = 1'b0;
        check_val("p2_alu_a", {8'd0, ALU_A}, 16'h0000);
        @(negedge CLK);
        check_val("ign_done", {15'd0, DONE}, 16'h0001);
        check_flags("ign", 16'h0002, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        check_val("ign_no_restart", {15'd0, BUSY}, 16'h0000);

        // RESET during P2 aborts the op with no DONE.
        @(negedge CLK);
        CMD = kAND; A16 = 16'hFFFF; B16 = 16'hFFFF; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_val("abort_busy_done", {14'd0, BUSY, DONE}, 16'h0000);
        check_flags("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_val("abort_alu", {ALU_A, ALU_B}, 16'h0000);
        done_seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            if (DONE) done_seen++;
        end
        check_val("abort_no_done", 16'(done_seen), 16'd0);

        // RESET and START together: RESET wins.
        @(negedge CLK);
        RESET = 1'b1; START = 1'b1; CMD = kLSH; A16 = 16'h1111;
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        check_val("rst_start_busy", {15'd0, BUSY}, 16'h0000);

        // START held high across two ops.
        @(negedge CLK);
        CMD = kLSH; A16 = 16'h4001; B16 = 16'h0000; CIN = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        CMD = kXOR; A16 = 16'h1234; B16 = 16'h00FF; CIN = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (n == 5) START = 1'b0;
            if (DONE) begin
                done_n.push_back(n);
                done_res.push_back(RESULT);
            end
        end
        check_val("held_done_count", 16'(done_n.size()), 16'd2);
        if (done_n.size() == 2) begin
            check_val("held_done1_cycle", 16'(done_n[0]), 16'd3);
            check_val("held_done_spacing", 16'(done_n[1] - done_n[0]), 16'd4);
            check_val("held_res1", done_res[0], 16'h8002);
            check_val("held_res2", done_res[1], 16'h12CB);
        end
        check_val("held_odd2", {15'd0, ODD16}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-cycle 16-bit operation sequencer that drives the combinational 8-bit ALU as its master.
- Accepts a 16-bit operand pair and an op_mne command.
- Issues two byte-wide ALU passes, chaining shift/carry between them, and assembles a 16-bit result with carry-out, zero and parity flags.
- Sits between the control/datapath and the ALU, so 16-bit shifts and logic ops are built from the same single-byte ALU instruction used for both LSW and MSW.

## Interface
Parameters:
- none; widths are fixed at 16-bit word, 8-bit byte.

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  reset, synchronous, active-high
- START  in  1  request; sampled only in IDLE
- CMD  in  3  op_mne command (kAND, kLSH, kRSH, kXOR; others = no-op)
- A16  in  16  operand A
- B16  in  16  operand B (ignored by shifts)
- CIN  in  1  shift-in bit for first pass
- BUSY  out  1  high in P1 and P2
- DONE  out  1  one-cycle pulse, result valid
- RESULT  out  16  assembled result, held until next accepted START
- COUT  out  1  shift-out of second pass
- ZERO16  out  1  RESULT == 0
- ODD16  out  1  1 = odd number of ones in RESULT
- ALU_A, ALU_B  out  8  byte operands to ALU
- ALU_OP  out  3  opcode to ALU
- ALU_SC_IN  out  1  shift/carry in to ALU
- ALU_OUT  in  8  ALU result
- ALU_SC_OUT  in  1  ALU shift/carry out
- ALU_BEVEN  in  1  ALU parity of ALU_OUT (1 = odd)

## Operation
- States:
  - IDLE -> P1 on START (latch CMD, A16, B16, CIN).
  - P1 -> P2 unconditionally.
  - P2 -> FIN unconditionally.
  - FIN -> IDLE unconditionally.
- Byte order:
  - kRSH: P1 = MSW, P2 = LSW, so the bit shifted out of the MSW enters bit 7 of the LSW.
  - All other commands: P1 = LSW, P2 = MSW.
- In P1 and P2, ALU_A and ALU_B are the selected byte of the latched operands, and ALU_OP is the latched CMD.
- ALU_SC_IN:
  - P1: latched CIN.
  - P2: ALU_SC_OUT registered at the end of P1.
- End of each pass registers ALU_OUT into the corresponding RESULT byte and ALU_BEVEN into a parity bit.
- Flags:
  - COUT = ALU_SC_OUT registered at the end of P2.
  - ODD16 = XOR of the two registered BEVEN bits.
  - ZERO16 = NOR of the assembled RESULT.
- kAND, kXOR: ALU forces SC_OUT = 0, so COUT = 0 and CIN has no effect.
- Undefined CMD: ALU returns 0, so RESULT = 0, COUT = 0, ZERO16 = 1, ODD16 = 0. Full sequence still runs.
- START outside IDLE (P1, P2, FIN) is ignored; operand inputs may change freely after the accept cycle.

## Timing
- START accepted at edge 0 (state IDLE).
- P1 during cycle 1, P2 during cycle 2, FIN during cycle 3.
- FIN cycle: DONE = 1, BUSY = 0.
- RESULT, COUT, ZERO16 and ODD16 become final at FIN and hold until the next accept.
- Latency: 3 cycles from accept to DONE.
- Maximum throughput: one op per 4 cycles when START is held high.
- ALU is combinational; its outputs are sampled in the same cycle the sequencer drives its inputs. No registered ALU stage.
- RESET (any state, including mid-operation):
  - Next state IDLE.
  - BUSY = 0, DONE = 0, RESULT = 0, COUT = 0, ZERO16 = 0, ODD16 = 0.
  - ALU_A = ALU_B = 0, ALU_OP = 0, ALU_SC_IN = 0.
  - Aborted op never pulses DONE.
- RESET and START asserted together: RESET wins, START is dropped.
- ZERO16 reads 0 out of reset, even though RESULT = 0. It is valid only from the first DONE onward.

## Structure
- Reuse op_mne and the k* opcode constants from package definitions. Do not duplicate encodings.
- Add a seq_state_t enum (IDLE, P1, P2, FIN) to definitions for waveform viewing.
- Single module, no sub-modules. The ALU is instantiated by the parent and connected through the ALU_* ports.
- A top-level bench wrapper instantiates alu_word_seq plus ALU.

## Test plan
- kLSH, A16 = 16'h80FF, CIN = 1 -> RESULT = 16'h01FF, COUT = 1, ODD16 = 1, ZERO16 = 0, DONE exactly 3 cycles after accept.
- kRSH, A16 = 16'h0180, CIN = 0 -> MSW pass outputs 8'h00 with SC = 1, which feeds the LSW pass -> RESULT = 16'h00C0, COUT = 0, ODD16 = 0.
- kXOR, A16 = B16 = 16'hA5A5, CIN = 1 -> RESULT = 16'h0000, ZERO16 = 1, COUT = 0, ODD16 = 0.
- kAND, A16 = 16'hF00F, B16 = 16'h3C3C -> RESULT = 16'h300C, ZERO16 = 0, ODD16 = 0. Then undefined CMD 3'b111 -> RESULT = 0, ZERO16 = 1.
- Second START with new operands during P1 -> ignored, first op's RESULT reported. RESET in P2 -> IDLE next cycle, all outputs 0, no DONE pulse.
- START held high across two ops (kLSH then kXOR, operands changed after the first accept) -> DONE pulses 4 cycles apart, each RESULT matches its own latched operands.
